// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard scoreboard: decoder latency/slack codes,
// mul/div busy defaults and the architectural register index type.
package hazard_pkg;

  localparam int NREG_DEFAULT  = 32;
  localparam int LAT_W_DEFAULT = 3;
  localparam int MD_W_DEFAULT  = 4;

  localparam int MUL_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT = 10;

  // Cycles after issue until a result can be forwarded.
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  // Cycles a consumer can still wait for an operand once it leaves D.
  localparam int SLACK_D = 0;
  localparam int SLACK_E = 1;
  localparam int SLACK_M = 2;

  localparam int REG_IDX_W = $clog2(NREG_DEFAULT);
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  function automatic bit fits_width(input int value, input int width);
    return value < (1 << width);
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: a saturating down-counter whose load takes priority over
// the decrement. Used per tracked register and for the mul/div busy timer.
module sb_entry #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register/HI-LO hazard scoreboard beside the D stage; raises a combinational stall.
// Define HAZARD_STATS_EN to add the stall_cycles / md_stall_cycles counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG       = NREG_DEFAULT,
  parameter int LAT_W      = LAT_W_DEFAULT,
  parameter int MD_W       = MD_W_DEFAULT,
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    d_valid,
  input  logic [$clog2(NREG)-1:0] d_rs,
  input  logic                    d_rs_en,
  input  logic [LAT_W-1:0]        d_rs_slack,
  input  logic [$clog2(NREG)-1:0] d_rt,
  input  logic                    d_rt_en,
  input  logic [LAT_W-1:0]        d_rt_slack,
  input  logic [$clog2(NREG)-1:0] d_dst,
  input  logic                    d_dst_we,
  input  logic [LAT_W-1:0]        d_dst_lat,
  input  logic                    d_md_start,
  input  logic                    d_md_div,
  input  logic                    d_md_use,
  output logic                    stall,
  output logic                    md_busy,
  output logic [NREG-1:0]         sb_pending
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             md_stall_cycles
`endif
);

  localparam int IDX_W = $clog2(NREG);

  if (!fits_width(MUL_CYCLES, MD_W) || !fits_width(DIV_CYCLES, MD_W)) begin : g_bad_md_cycles
    $error("hazard_scoreboard: MUL_CYCLES/DIV_CYCLES do not fit in MD_W bits");
  end

  logic [LAT_W-1:0] w_cnt [NREG];
  logic [MD_W-1:0]  w_mdCnt;
  logic [MD_W-1:0]  w_mdLoadVal;
  logic             w_rawRs;
  logic             w_rawRt;
  logic             w_mdHaz;
  logic             w_issue;
  logic             w_dstLoad;
  logic             w_mdLoad;

  assign w_cnt[0] = '0;

  // Sources are checked against pre-update counts, so an instruction never waits on itself.
  assign w_rawRs = d_valid & d_rs_en & (d_rs != '0) & (w_cnt[d_rs] > d_rs_slack);
  assign w_rawRt = d_valid & d_rt_en & (d_rt != '0) & (w_cnt[d_rt] > d_rt_slack);
  assign w_mdHaz = d_valid & d_md_use & md_busy;

  assign stall   = w_rawRs | w_rawRt | w_mdHaz;
  assign w_issue = d_valid & ~stall;

  // A zero latency means the result is never tracked, so it must not clear an older count.
  assign w_dstLoad = w_issue & d_dst_we & (d_dst_lat != '0);

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    sb_entry #(.W(LAT_W)) u_entry (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_dstLoad & (d_dst == IDX_W'(r))),
      .i_load_val (d_dst_lat),
      .o_count    (w_cnt[r])
    );
  end

  assign w_mdLoad    = w_issue & d_md_start;
  assign w_mdLoadVal = d_md_div ? MD_W'(DIV_CYCLES) : MD_W'(MUL_CYCLES);

  sb_entry #(.W(MD_W)) u_md_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_mdLoad),
    .i_load_val (w_mdLoadVal),
    .o_count    (w_mdCnt)
  );

  assign md_busy = (w_mdCnt != '0);

  always_comb begin
    sb_pending = '0;
    for (int r = 1; r < NREG; r++) begin
      sb_pending[r] = (w_cnt[r] != '0);
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stallCycles;
  logic [31:0] r_mdStallCycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCycles   <= '0;
      r_mdStallCycles <= '0;
    end else begin
      if (stall) begin
        r_stallCycles <= r_stallCycles + 32'd1;
      end
      if (w_mdHaz) begin
        r_mdStallCycles <= r_mdStallCycles + 32'd1;
      end
    end
  end

  assign stall_cycles    = r_stallCycles;
  assign md_stall_cycles = r_mdStallCycles;
`endif

endmodule
